instr_fetch: RTL

Fetch stage of the five-stage WISC pipeline and the producer end of the instruction interface consumed by decode. It owns the PC and drives a variable-latency instruction-memory read handshake. It loads the IF/ID pipeline register with the instruction word and PC+2, which decode uses as its `instruction` and `pc` inputs. It honours stalls from the hazard unit, redirects from branch/jump resolution, and stops on HALT.

---
 rtl/instr_fetch.sv | 118 +++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: WISC fetch stage. Owns the PC, drives a variable-latency
// instruction-memory read handshake and loads the IF/ID register
// (instruction word, PC+2, valid) consumed by decode.
module instr_fetch #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  output logic        imem_rd,
  input  logic [15:0] imem_rdata,
  input  logic        imem_done,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] instr_out,
  output logic [15:0] pc_plus2,
  output logic        instr_valid,
  output logic        halted,
  output logic        err
);

  typedef enum logic [1:0] {S_REQ, S_HOLD, S_HALT} state_t;

  state_t      state_q;
  logic [15:0] pc_q;
  logic [15:0] pc_inc;
  logic [15:0] skid_instr_q;
  logic [15:0] skid_pc2_q;
  logic [15:0] instr_q;
  logic [15:0] pc2_q;
  logic        valid_q;
  logic        err_q;

  function automatic logic is_halt(input logic [15:0] word);
    return word[15:11] == HALT_OPC;
  endfunction

  // PC arithmetic wraps naturally at 16 bits.
  assign pc_inc      = pc_q + 16'd2;

  // Memory request is only issued while actively fetching and out of reset.
  assign imem_rd     = rst && (state_q == S_REQ);
  assign imem_addr   = pc_q;

  assign instr_out   = instr_q;
  assign pc_plus2    = pc2_q;
  assign instr_valid = valid_q;
  assign halted      = (state_q == S_HALT);
  assign err         = err_q;

  // Fetch FSM: PC, skid buffer, IF/ID register and sticky error.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      skid_instr_q <= NOP_INSTR;
      skid_pc2_q   <= 16'h0000;
      instr_q      <= NOP_INSTR;
      pc2_q        <= 16'h0000;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
    end else if (redirect) begin
      // Flush: any word returned this cycle and any skid contents are dropped.
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      if (redirect_pc[0]) begin
        err_q   <= 1'b1;
        state_q <= S_HALT;
      end else begin
        pc_q    <= redirect_pc;
        state_q <= S_REQ;
      end
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (imem_done) begin
            if (stall) begin
              // Decode is busy: park the word so it is neither lost nor refetched.
              skid_instr_q <= imem_rdata;
              skid_pc2_q   <= pc_inc;
              state_q      <= S_HOLD;
            end else begin
              instr_q <= imem_rdata;
              pc2_q   <= pc_inc;
              valid_q <= 1'b1;
              pc_q    <= pc_inc;
              state_q <= is_halt(imem_rdata) ? S_HALT : S_REQ;
            end
          end else if (!stall) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            instr_q <= skid_instr_q;
            pc2_q   <= skid_pc2_q;
            valid_q <= 1'b1;
            pc_q    <= pc_inc;
            state_q <= is_halt(skid_instr_q) ? S_HALT : S_REQ;
          end
        end
        S_HALT: begin
          // The HALT word stays visible until decode accepts it, then bubbles.
          if (!stall) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

endmodule
